// File: rtl/kws_result_argmax.sv
// Running argmax over one signed score per class per frame, with valid/ack result handshake,
// committed score bank for readback, and sticky error flags. Optional macro: KWS_THRESHOLD_EN.
module kws_result_argmax #(
    parameter int unsigned NUM_CLASSES = 12,
    parameter int unsigned CLS_W       = 4,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] serial_result,
    input  logic              serial_result_valid,
    input  logic              done,
    input  logic              clear,
    input  logic              class_ack,
    input  logic [CLS_W-1:0]  rd_idx,
`ifdef KWS_THRESHOLD_EN
    input  logic [DATA_W-1:0] score_thresh,
`endif
    output logic [DATA_W-1:0] rd_score,
    output logic [CLS_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_score,
    output logic              class_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun,
    output logic [7:0]        frame_cnt
);

    localparam logic [CLS_W-1:0] LastIdx = CLS_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDecide} state_e;

    state_e            state_q, state_d;
    logic [CLS_W-1:0]  count_q, count_d;
    logic [CLS_W-1:0]  maxidx_q, maxidx_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] work_q [NUM_CLASSES];
    logic [DATA_W-1:0] comm_q [NUM_CLASSES];
    logic              wr_en, commit;
    logic [CLS_W-1:0]  wr_idx;
    logic              class_valid_q, class_valid_d;
    logic [CLS_W-1:0]  class_idx_q, class_idx_d;
    logic [DATA_W-1:0] class_score_q, class_score_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0] rd_score_q, rd_score_d;
    logic              byte_gt, last_byte;
    logic [CLS_W-1:0]  decide_idx;

    assign byte_gt   = $signed(serial_result) > $signed(max_q);
    assign last_byte = serial_result_valid && (count_q == LastIdx);

`ifdef KWS_THRESHOLD_EN
    // Scores below threshold report the all-ones "unknown" class.
    assign decide_idx = ($signed(max_q) < $signed(score_thresh)) ? '1 : maxidx_q;
`else
    assign decide_idx = maxidx_q;
`endif

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        max_d         = max_q;
        maxidx_d      = maxidx_q;
        wr_en         = 1'b0;
        wr_idx        = count_q;
        commit        = 1'b0;
        class_valid_d = class_valid_q & ~class_ack;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        frame_err_d   = frame_err_q;
        overrun_d     = overrun_q;
        frame_cnt_d   = frame_cnt_q;

        if (clear) begin
            state_d       = StIdle;
            count_d       = '0;
            class_valid_d = 1'b0;
            frame_err_d   = 1'b0;
            overrun_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (serial_result_valid) begin
                        state_d  = StCollect;
                        count_d  = CLS_W'(1);
                        max_d    = serial_result;
                        maxidx_d = '0;
                        wr_en    = 1'b1;
                        wr_idx   = '0;
                    end
                end
                StCollect: begin
                    if (done && !last_byte) begin
                        // Short frame: drop it, including any byte arriving with done.
                        state_d     = StIdle;
                        count_d     = '0;
                        frame_err_d = 1'b1;
                    end else if (serial_result_valid) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CLS_W'(1);
                        if (byte_gt) begin
                            max_d    = serial_result;
                            maxidx_d = count_q;
                        end
                        if (last_byte) state_d = StDecide;
                    end
                end
                StDecide: begin
                    commit        = 1'b1;
                    class_valid_d = 1'b1;
                    class_idx_d   = decide_idx;
                    class_score_d = max_q;
                    frame_cnt_d   = frame_cnt_q + 8'd1;
                    if (class_valid_q && !class_ack) overrun_d = 1'b1;
                    if (serial_result_valid) begin
                        state_d  = StCollect;
                        count_d  = CLS_W'(1);
                        max_d    = serial_result;
                        maxidx_d = '0;
                        wr_en    = 1'b1;
                        wr_idx   = '0;
                    end else begin
                        state_d = StIdle;
                        count_d = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        rd_score_d = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (rd_idx == CLS_W'(i)) rd_score_d = comm_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            count_q       <= '0;
            max_q         <= '0;
            maxidx_q      <= '0;
            class_valid_q <= 1'b0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            frame_cnt_q   <= '0;
            rd_score_q    <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                work_q[i] <= '0;
                comm_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            max_q         <= max_d;
            maxidx_q      <= maxidx_d;
            class_valid_q <= class_valid_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
            frame_cnt_q   <= frame_cnt_d;
            rd_score_q    <= rd_score_d;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (commit) comm_q[i] <= work_q[i];
                if (wr_en && (wr_idx == CLS_W'(i))) work_q[i] <= serial_result;
            end
        end
    end

    assign rd_score    = rd_score_q;
    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;
    assign class_valid = class_valid_q;
    assign busy        = (state_q != StIdle);
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_kws_result_argmax.sv
// Bench for kws_result_argmax: fixed vector table, hand sequences for flags/handshake,
// and random frames checked against a simple argmax model.
module tb_kws_result_argmax;

    typedef struct packed {
        logic [11:0][7:0] sc;
        logic [3:0]       idx;
        logic [7:0]       score;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] serial_result;
    logic       serial_result_valid;
    logic       done;
    logic       clear;
    logic       class_ack;
    logic [3:0] rd_idx;
    logic [7:0] rd_score;
    logic [3:0] class_idx;
    logic [7:0] class_score;
    logic       class_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic [7:0] frame_cnt;
`ifdef KWS_THRESHOLD_EN
    logic [7:0] score_thresh;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0]       exp_cnt;
    logic [11:0][7:0] comm_m;
    vec_t             vecs [6];

    always #5 clk = ~clk;

    kws_result_argmax dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .serial_result       (serial_result),
        .serial_result_valid (serial_result_valid),
        .done                (done),
        .clear               (clear),
        .class_ack           (class_ack),
        .rd_idx              (rd_idx),
`ifdef KWS_THRESHOLD_EN
        .score_thresh        (score_thresh),
`endif
        .rd_score            (rd_score),
        .class_idx           (class_idx),
        .class_score         (class_score),
        .class_valid         (class_valid),
        .busy                (busy),
        .frame_err           (frame_err),
        .overrun             (overrun),
        .frame_cnt           (frame_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0][7:0] pack12(input int a [12]);
        logic [11:0][7:0] p;
        for (int i = 0; i < 12; i++) p[i] = a[i][7:0];
        return p;
    endfunction

    // Reference: first index of the maximum signed score, then optional threshold.
    function automatic void ref_argmax(input logic [11:0][7:0] sc, output logic [3:0] idx,
                                       output logic [7:0] score);
        int best;
        int bi;
        best = int'($signed(sc[0]));
        bi   = 0;
        for (int i = 1; i < 12; i++) begin
            if (int'($signed(sc[i])) > best) begin
                best = int'($signed(sc[i]));
                bi   = i;
            end
        end
        idx   = bi[3:0];
        score = best[7:0];
`ifdef KWS_THRESHOLD_EN
        if (best < int'($signed(score_thresh))) idx = 4'hf;
`endif
    endfunction

    task automatic send_frame(input logic [11:0][7:0] sc, input int gap_pct, input bit done_last);
        for (int i = 0; i < 12; i++) begin
            for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
                serial_result_valid = 1'b0;
                step();
            end
            serial_result       = sc[i];
            serial_result_valid = 1'b1;
            done                = done_last && (i == 11);
            step();
        end
        serial_result_valid = 1'b0;
        done                = 1'b0;
    endtask

    // Finishes a frame that has just had its last byte sampled and checks it against the model.
    task automatic finish_model(input logic [11:0][7:0] sc, input string name);
        logic [3:0] ei;
        logic [7:0] es;
        step();
        ref_argmax(sc, ei, es);
        exp_cnt = exp_cnt + 8'd1;
        comm_m  = sc;
        chk({name, "_valid"}, class_valid, 1);
        chk({name, "_idx"}, class_idx, ei);
        chk({name, "_score"}, class_score, es);
        chk({name, "_cnt"}, frame_cnt, exp_cnt);
    endtask

    task automatic ack_result(input string name);
        class_ack = 1'b1;
        step();
        class_ack = 1'b0;
        chk({name, "_ack_clears"}, class_valid, 0);
    endtask

    initial begin
        int a [12];
        int ri;
        logic [11:0][7:0] sc;

        reset_n = 1'b0; serial_result = '0; serial_result_valid = 1'b0; done = 1'b0;
        clear = 1'b0; class_ack = 1'b0; rd_idx = '0;
`ifdef KWS_THRESHOLD_EN
        score_thresh = 8'h80;
`endif
        exp_cnt = '0;
        comm_m  = '0;

        a = '{0, 5, -3, 7, 7, 2, -1, 4, 6, -8, 3, 1};
        vecs[0] = '{sc: pack12(a), idx: 4'd3, score: 8'd7};
        a = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -100, -128, -128};
        vecs[1] = '{sc: pack12(a), idx: 4'd9, score: 8'h9c};
        a = '{42, 42, 42, 42, 42, 42, 42, 42, 42, 42, 42, 42};
        vecs[2] = '{sc: pack12(a), idx: 4'd0, score: 8'd42};
        a = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10, -11, 127};
        vecs[3] = '{sc: pack12(a), idx: 4'd11, score: 8'd127};
        a = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
        vecs[4] = '{sc: pack12(a), idx: 4'd0, score: 8'h80};
        a = '{-5, -3, -3, -9, -3, -100, -50, -4, -3, -7, -8, -6};
        vecs[5] = '{sc: pack12(a), idx: 4'd1, score: 8'hfd};

        step();
        step();
        chk("rst_valid", class_valid, 0);
        chk("rst_idx", class_idx, 0);
        chk("rst_score", class_score, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {frame_err, overrun}, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_rd", rd_score, 0);
        reset_n = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].sc, 0, 1'b0);
            chk("tbl_not_yet_valid", class_valid, 0);
            chk("tbl_busy_decide", busy, 1);
            step();
            exp_cnt = exp_cnt + 8'd1;
            comm_m  = vecs[v].sc;
            chk("tbl_valid", class_valid, 1);
            chk("tbl_idx", class_idx, vecs[v].idx);
            chk("tbl_score", class_score, vecs[v].score);
            chk("tbl_cnt", frame_cnt, exp_cnt);
            chk("tbl_busy_done", busy, 0);
            rd_idx = vecs[v].idx;
            step();
            chk("tbl_rd", rd_score, vecs[v].score);
            ack_result("tbl");
        end

        // Readback latency and out-of-range index.
        rd_idx = 4'd5;
        step();
        chk("rd_idx5", rd_score, 8'h9c);
        rd_idx = 4'd0;
        #1;
        chk("rd_latency_hold", rd_score, 8'h9c);
        step();
        chk("rd_idx0", rd_score, 8'hfb);
        rd_idx = 4'd13;
        step();
        chk("rd_oob", rd_score, 0);

        // done in IDLE is ignored.
        done = 1'b1;
        step();
        done = 1'b0;
        chk("done_idle_err", frame_err, 0);
        chk("done_idle_busy", busy, 0);

        // Short frame: 5 bytes then done with a byte alongside it.
        for (int i = 0; i < 5; i++) begin
            serial_result = 8'd100; serial_result_valid = 1'b1;
            step();
        end
        done = 1'b1;
        step();
        done = 1'b0; serial_result_valid = 1'b0;
        chk("short_err", frame_err, 1);
        chk("short_valid", class_valid, 0);
        chk("short_cnt", frame_cnt, exp_cnt);
        chk("short_busy", busy, 0);
        chk("short_idx_kept", class_score, 8'hfd);
        rd_idx = 4'd1;
        step();
        chk("short_bank_kept", rd_score, 8'hfd);
        send_frame(vecs[0].sc, 0, 1'b1);
        finish_model(vecs[0].sc, "after_short");
        chk("after_short_err", frame_err, 1);
        ack_result("after_short");

        // Back-to-back frames without ack set overrun.
        send_frame(vecs[0].sc, 0, 1'b0);
        send_frame(vecs[3].sc, 0, 1'b0);
        exp_cnt = exp_cnt + 8'd1;
        chk("b2b_busy", busy, 1);
        finish_model(vecs[3].sc, "b2b");
        chk("b2b_overrun", overrun, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_flags", {class_valid, frame_err, overrun}, 0);

        // Same, but ack lands on frame 2's latch edge.
        send_frame(vecs[0].sc, 0, 1'b0);
        send_frame(vecs[1].sc, 0, 1'b0);
        exp_cnt = exp_cnt + 8'd1;
        class_ack = 1'b1;
        finish_model(vecs[1].sc, "b2b_ack");
        class_ack = 1'b0;
        chk("b2b_ack_overrun", overrun, 0);
        ack_result("b2b_ack");

        // clear mid-frame (with a byte on the same cycle), then reset during COLLECT.
        send_frame(vecs[0].sc, 0, 1'b0);
        finish_model(vecs[0].sc, "pre_clr");
        for (int i = 0; i < 6; i++) begin
            serial_result = 8'd50; serial_result_valid = 1'b1;
            step();
        end
        clear = 1'b1; serial_result = 8'd127;
        step();
        clear = 1'b0; serial_result_valid = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_valid", class_valid, 0);
        chk("clr_keep_idx", class_idx, 3);
        chk("clr_keep_score", class_score, 7);
        chk("clr_keep_cnt", frame_cnt, exp_cnt);
        for (int i = 0; i < 3; i++) begin
            serial_result = 8'd9; serial_result_valid = 1'b1;
            step();
        end
        serial_result_valid = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        exp_cnt = '0;
        comm_m  = '0;
        chk("rst2_busy", busy, 0);
        chk("rst2_out", {class_valid, class_idx, class_score, frame_err, overrun}, 0);
        chk("rst2_cnt", frame_cnt, 0);
        rd_idx = 4'd0;
        step();
        chk("rst2_rd", rd_score, 0);
        send_frame(vecs[5].sc, 0, 1'b0);
        finish_model(vecs[5].sc, "post_rst");
        ack_result("post_rst");

`ifdef KWS_THRESHOLD_EN
        score_thresh = 8'd10;
        send_frame(vecs[0].sc, 0, 1'b0);
        finish_model(vecs[0].sc, "thr10");
        chk("thr10_idx_const", class_idx, 4'hf);
        ack_result("thr10");
        score_thresh = 8'd7;
        send_frame(vecs[0].sc, 0, 1'b0);
        finish_model(vecs[0].sc, "thr7");
        chk("thr7_idx_const", class_idx, 4'd3);
        ack_result("thr7");
        score_thresh = 8'h80;
`endif

        // Random frames with gaps, occasional done on the last byte, and readback.
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 12; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ri = $urandom_range(0, 4);
                    sc[i] = 8'(ri - 2);
                end else begin
                    sc[i] = 8'($urandom_range(0, 255));
                end
            end
            send_frame(sc, 25, $urandom_range(0, 3) == 0);
            finish_model(sc, "rnd");
            ri = $urandom_range(0, 15);
            rd_idx = 4'(ri);
            step();
            chk("rnd_rd", rd_score, (ri < 12) ? 32'(comm_m[ri]) : 32'd0);
            ack_result("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kws_result_argmax.md
Name: kws_result_argmax

Overview:
- Downstream consumer of the CNN accelerator's serial result stream in the keyword-spotting datapath.
- Collects one signed 8-bit score per class per frame and computes a running argmax.
- Publishes the winning class index and score with a valid/ack handshake to host logic (LA/Wishbone side).
- Keeps a committed copy of the last frame's scores for readback, and flags short frames and unacknowledged overruns.

Parameters:
NUM_CLASSES, 12, scores per frame; 2..(2^CLS_W)-2
CLS_W, 4, class index width
DATA_W, 8, score width, two's complement

Ports:
clk  in  1  system clock
reset_n  in  1  reset, synchronous, active-low
serial_result  in  DATA_W  signed class score from accelerator
serial_result_valid  in  1  score byte valid, one byte per cycle max
done  in  1  accelerator end-of-inference pulse
clear  in  1  synchronous soft clear
class_ack  in  1  host acknowledges class_valid
rd_idx  in  CLS_W  readback class select
rd_score  out  DATA_W  committed score of rd_idx
class_idx  out  CLS_W  winning class
class_score  out  DATA_W  winning score
class_valid  out  1  result pending
busy  out  1  frame in progress
frame_err  out  1  sticky short-frame error
overrun  out  1  sticky result-overwritten error
frame_cnt  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (reset_n=0 at a clk edge): all outputs 0, both score banks 0, count 0, state IDLE. Synchronous only, so there is no effect between edges.
- FSM states:
  - IDLE. Valid byte -> COLLECT, count=1, max=byte, maxidx=0.
  - COLLECT. Each valid byte: store to working bank[count], count++.
    - Byte > max: max=byte, maxidx=count.
    - Ties keep the lower index (strict greater-than compare).
    - Byte with count==NUM_CLASSES-1 completes the frame -> DECIDE.
  - DECIDE (one cycle). Working bank copied to committed bank. class_idx/class_score/class_valid=1 and frame_cnt++ take effect at the clock edge ending DECIDE. A valid byte during DECIDE starts the next frame (count=1, go COLLECT).
- Latency: last byte sampled at edge k -> class_valid high after edge k+1. Back-to-back frames are sustained with no gaps.
- busy=1 in COLLECT and DECIDE.
- done handling:
  - done in IDLE or DECIDE: ignored.
  - done in COLLECT on the same cycle as the completing byte: normal completion.
  - done in COLLECT otherwise: frame_err=1, partial frame discarded, committed bank and outputs unchanged, -> IDLE. A valid byte on that same cycle is discarded.
- Handshake:
  - class_valid is held until class_ack is sampled high while class_valid=1; it then clears the next cycle.
  - ack with class_valid=0 is ignored.
  - New result latched on the same edge as an accepted ack: class_valid stays 1, no overrun.
  - New result latched while class_valid=1 and no ack: overwrite outputs, overrun=1.
- Readback: rd_score registered, one-cycle latency, from the committed bank. rd_idx>=NUM_CLASSES returns 0.
- clear:
  - Aborts any frame -> IDLE.
  - Clears class_valid, frame_err and overrun.
  - Retains class_idx, class_score, frame_cnt and the committed bank.
  - Has priority over all other inputs that cycle.
- Arithmetic: signed DATA_W compare, no saturation. -128 is a valid score.

Optional Feature:
- Macro KWS_THRESHOLD_EN.
- Defined:
  - Adds input port score_thresh (DATA_W, signed).
  - At DECIDE, if max < score_thresh (signed): class_idx = all-ones (2^CLS_W-1, "unknown"), class_score=max.
  - class_valid, overrun and frame_cnt behave as normal.
- Undefined: no port; the true argmax index is always reported.

Test Plan:
- Reset then 12 bytes 0,5,-3,7,7,2,...,1 consecutive -> class_valid after edge k+1, class_idx=3, class_score=7, frame_cnt=1, busy=0.
- Frame of scores -128 except byte 9=-100; rd_idx=9 -> class_idx=9, class_score=-100, rd_score=-100 one cycle later; rd_idx=13 -> 0.
- done after 5 bytes -> frame_err=1, class_valid stays 0, frame_cnt=0; then a full valid frame completes normally with frame_err still 1.
- Two back-to-back frames, no ack -> overrun=1, outputs show frame 2. Repeat with ack asserted on frame 2's latch edge -> overrun=0, class_valid=1.
- clear mid-frame after 6 bytes, then reset_n=0 for one edge during COLLECT -> IDLE, flags 0, next 12-byte frame gives correct argmax.
- KWS_THRESHOLD_EN, score_thresh=10, max=7 -> class_idx=15, class_score=7. score_thresh=7 -> true index.
